// File: rtl/vpu_writeback_collector.sv
// Re-aligns the two skewed VPU lanes in per-lane FIFOs and writes each {lane2, lane1} pair to the unified buffer;
// wr_en rises 2 cycles after the later lane of a pair; wr_ready stalls are absorbed by the FIFOs, the VPU is never stalled.
module vpu_writeback_collector #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   num_rows,
    input  logic [DATA_W-1:0]   vpu_data_in_1,
    input  logic [DATA_W-1:0]   vpu_data_in_2,
    input  logic                vpu_valid_in_1,
    input  logic                vpu_valid_in_2,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [2*DATA_W-1:0] wr_data,
    input  logic                wr_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] lane2;
        logic [DATA_W-1:0] lane1;
    } pair_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] num_rows_q, num_rows_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] push_cnt_q [2];
    logic [ADDR_W-1:0] push_cnt_d [2];
    logic [DATA_W-1:0] mem_q [2][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [2][FIFO_DEPTH];
    logic [PTR_W:0]    wptr_q [2];
    logic [PTR_W:0]    wptr_d [2];
    logic [PTR_W:0]    rptr_q [2];
    logic [PTR_W:0]    rptr_d [2];
    logic              wr_en_q, wr_en_d;
    logic              overflow_q, overflow_d;
    pair_t             wr_data_q, wr_data_d, head_dat;

    logic [1:0]              fifo_empty, fifo_full, lane_vld;
    logic [1:0][DATA_W-1:0]  lane_dat, head_lane;
    logic                    pair_load, wr_accept;

    assign lane_vld = {vpu_valid_in_2, vpu_valid_in_1};
    assign lane_dat = {vpu_data_in_2, vpu_data_in_1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = (wptr_q[k] == rptr_q[k]);
            fifo_full[k]  = (wptr_q[k][PTR_W] != rptr_q[k][PTR_W]) &&
                            (wptr_q[k][PTR_W-1:0] == rptr_q[k][PTR_W-1:0]);
            head_lane[k]  = mem_q[k][rptr_q[k][PTR_W-1:0]];
        end
    end

    assign head_dat  = {head_lane[1], head_lane[0]};
    assign wr_accept = wr_en_q & wr_ready;
    assign pair_load = (state_q == S_COLLECT) & ~fifo_empty[0] & ~fifo_empty[1] & (~wr_en_q | wr_ready);

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        wr_cnt_d   = wr_cnt_q;
        wr_addr_d  = wr_addr_q;
        push_cnt_d = push_cnt_q;
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        wr_en_d    = wr_en_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            wr_cnt_d  = wr_cnt_q + ADDR_ONE;
        end

        if (pair_load) begin
            rptr_d[0] = rptr_q[0] + PTR_ONE;
            rptr_d[1] = rptr_q[1] + PTR_ONE;
            wr_data_d = head_dat;
            wr_en_d   = 1'b1;
        end else if (wr_accept) begin
            wr_en_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_rows_d    = num_rows;
                    wr_addr_d     = base_addr;
                    wr_cnt_d      = '0;
                    push_cnt_d[0] = '0;
                    push_cnt_d[1] = '0;
                    overflow_d    = 1'b0;
                    state_d       = (num_rows == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A full FIFO popped this cycle frees its slot, so the push still lands.
                for (int k = 0; k < 2; k++) begin
                    if (lane_vld[k]) begin
                        if (push_cnt_q[k] == num_rows_q || (fifo_full[k] && !pair_load)) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_d[k][wptr_q[k][PTR_W-1:0]] = lane_dat[k];
                            wptr_d[k]     = wptr_q[k] + PTR_ONE;
                            push_cnt_d[k] = push_cnt_q[k] + ADDR_ONE;
                        end
                    end
                end
                if (wr_accept && (wr_cnt_q + ADDR_ONE) == num_rows_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_rows_q <= '0;
            wr_cnt_q   <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                push_cnt_q[k] <= '0;
                wptr_q[k]     <= '0;
                rptr_q[k]     <= '0;
            end
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            overflow_q <= overflow_d;
            push_cnt_q <= push_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage needs no reset: reset empties the FIFOs through the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == S_COLLECT);
    assign done     = (state_q == S_DONE);
    assign overflow = overflow_q;
endmodule

// File: tb/tb_vpu_writeback_collector.sv
// Bench for vpu_writeback_collector: directed vector table, multi-cycle corner sequences and a random run
// against a queue-based reference model that is compared every cycle.
module tb_vpu_writeback_collector;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEPTH = 4;

    logic          clk, rst, start;
    logic [AW-1:0] base_addr, num_rows;
    logic [DW-1:0] vpu_data_in_1, vpu_data_in_2;
    logic          vpu_valid_in_1, vpu_valid_in_2;
    logic          wr_en, wr_ready, busy, done, overflow;
    logic [AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;

    vpu_writeback_collector #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .vpu_data_in_1(vpu_data_in_1), .vpu_data_in_2(vpu_data_in_2),
        .vpu_valid_in_1(vpu_valid_in_1), .vpu_valid_in_2(vpu_valid_in_2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per lane, one output slot, transaction bookkeeping.
    bit            sb_on = 0;
    logic [DW-1:0] q1[$], q2[$];
    bit            m_busy, m_done, m_ovf, m_en;
    logic [AW-1:0] m_addr, m_rows, m_wcnt;
    logic [2*DW-1:0] m_data;
    int            m_cnt1, m_cnt2;

    typedef struct {
        int st, base, rows, v1, d1, v2, d2, rdy;
        int en, addr, data, bsy, dn, ovf;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset;
        q1.delete(); q2.delete();
        m_busy = 0; m_done = 0; m_ovf = 0; m_en = 0;
        m_addr = '0; m_rows = '0; m_wcnt = '0; m_data = '0;
        m_cnt1 = 0; m_cnt2 = 0;
    endtask

    // Called at the falling edge: compare this cycle's outputs, then advance over the next rising edge.
    task automatic model_step;
        bit acc, pop;
        logic [DW-1:0] h1, h2;
        if (sb_on) begin
            checks++;
            if ({wr_en, wr_addr, wr_data, busy, done, overflow} !== {m_en, m_addr, m_data, m_busy, m_done, m_ovf}) begin
                errors++;
                $display("FAIL model t=%0t got en=%b a=%h d=%h busy=%b done=%b ovf=%b want en=%b a=%h d=%h busy=%b done=%b ovf=%b",
                         $time, wr_en, wr_addr, wr_data, busy, done, overflow,
                         m_en, m_addr, m_data, m_busy, m_done, m_ovf);
            end
        end
        if (rst) begin
            model_reset();
            return;
        end
        acc = m_en && wr_ready;
        pop = m_busy && q1.size() > 0 && q2.size() > 0 && (!m_en || wr_ready);
        h1 = '0; h2 = '0;
        if (pop) begin
            h1 = q1.pop_front();
            h2 = q2.pop_front();
        end
        if (m_busy) begin
            if (vpu_valid_in_1) begin
                if (m_cnt1 == int'(m_rows) || q1.size() >= DEPTH) m_ovf = 1;
                else begin q1.push_back(vpu_data_in_1); m_cnt1++; end
            end
            if (vpu_valid_in_2) begin
                if (m_cnt2 == int'(m_rows) || q2.size() >= DEPTH) m_ovf = 1;
                else begin q2.push_back(vpu_data_in_2); m_cnt2++; end
            end
        end
        if (acc) begin
            m_addr = m_addr + 8'd1;
            m_wcnt = m_wcnt + 8'd1;
        end
        if (pop) begin
            m_en = 1;
            m_data = {h2, h1};
        end else if (acc) begin
            m_en = 0;
        end
        if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (acc && m_wcnt == m_rows) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (start) begin
            m_rows = num_rows; m_addr = base_addr; m_wcnt = '0;
            m_cnt1 = 0; m_cnt2 = 0; m_ovf = 0;
            if (num_rows == '0) m_done = 1;
            else m_busy = 1;
        end
    endtask

    task automatic tick;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int st, input int base, input int rows, input int v1, input int d1,
                         input int v2, input int d2, input int rdy);
        start = st[0];
        base_addr = base[AW-1:0];
        num_rows = rows[AW-1:0];
        vpu_valid_in_1 = v1[0];
        vpu_data_in_1 = d1[DW-1:0];
        vpu_valid_in_2 = v2[0];
        vpu_data_in_2 = d2[DW-1:0];
        wr_ready = rdy[0];
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, " wr_data"}, wr_data, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        vec_t t;
        int rows, base, tot1, tot2, skew, s1, s2, v1, v2;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        // {st,base,rows, v1,d1,v2,d2, rdy, en,addr,data, busy,done,ovf}
        // aligned lanes, start in COLLECT ignored
        vecs.push_back('{1, 'h10, 3, 0, 0, 0, 0, 1,      0, 0, 0,             0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h1, 1, 'h2, 1,     0, 0, 0,             1, 0, 0});
        vecs.push_back('{1, 'h99, 1, 1, 'h3, 1, 'h4, 1,  0, 0, 0,             1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h5, 1, 'h6, 1,     1, 'h10, 'h00020001, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h11, 'h00040003, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h12, 'h00060005, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 0, 0});
        // lane 2 one cycle behind
        vecs.push_back('{1, 'h20, 4, 0, 0, 0, 0, 1,      0, 0, 0,             0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h1, 0, 0, 1,       0, 0, 0,             1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h2, 1, 'hA, 1,     0, 0, 0,             1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h3, 1, 'hB, 1,     0, 0, 0,             1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h4, 1, 'hC, 1,     1, 'h20, 'h000A0001, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 'hD, 1,       1, 'h21, 'h000B0002, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h22, 'h000C0003, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h23, 'h000D0004, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 0, 0});
        // backpressure: wr_ready low in cycles 2..5
        vecs.push_back('{1, 'h30, 4, 0, 0, 0, 0, 1,      0, 0, 0,             0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h11, 1, 'h21, 1,   0, 0, 0,             1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h12, 1, 'h22, 0,   0, 0, 0,             1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h13, 1, 'h23, 0,   1, 'h30, 'h00210011, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 'h14, 1, 'h24, 0,   1, 'h30, 'h00210011, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,         1, 'h30, 'h00210011, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h30, 'h00210011, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h31, 'h00220012, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h32, 'h00230013, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         1, 'h33, 'h00240014, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 0, 0});
        // zero rows, start in DONE ignored
        vecs.push_back('{1, 'h50, 0, 0, 0, 0, 0, 1,      0, 0, 0,             0, 0, 0});
        vecs.push_back('{1, 'h60, 5, 0, 0, 0, 0, 1,      0, 0, 0,             0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0,             0, 0, 0});

        repeat (3) tick();
        rst = 1'b0;
        sb_on = 1;
        chk_idle_zero("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(t.en));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(t.bsy));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(t.dn));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(t.ovf));
            if (t.en != 0) begin
                chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(t.addr));
                chk($sformatf("vec%0d wr_data", i), wr_data, 32'(t.data));
            end
            drive(t.st, t.base, t.rows, t.v1, t.d1, t.v2, t.d2, t.rdy);
            tick();
        end

        // Full FIFO: fifth lane-1 push with no lane 2 and no drain
        drive(1, 0, 8, 0, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("full pre-push%0d overflow", k), 32'(overflow), 32'd0);
            drive(0, 0, 0, 1, k, 0, 0, 0); tick();
        end
        chk("full overflow set", 32'(overflow), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("full overflow sticky", 32'(overflow), 32'd1);
        chk("full busy", 32'(busy), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_idle_zero("full reset");

        // Excess element on lane 1, then the next start clears overflow
        drive(1, 'h60, 1, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 'h77, 1, 'h88, 1); tick();
        drive(0, 0, 0, 1, 'h99, 0, 0, 1); tick();
        chk("excess overflow", 32'(overflow), 32'd1);
        chk("excess wr_en", 32'(wr_en), 32'd1);
        chk("excess wr_addr", 32'(wr_addr), 32'h60);
        chk("excess wr_data", wr_data, 32'h00880077);
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        chk("excess done", 32'(done), 32'd1);
        tick();
        chk("excess overflow idle", 32'(overflow), 32'd1);
        drive(1, 'h70, 0, 0, 0, 0, 0, 1); tick();
        chk("restart clears overflow", 32'(overflow), 32'd0);
        chk("restart done", 32'(done), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();

        // Reset after two of four writes, then a fresh two-row transaction
        drive(1, 'h50, 4, 0, 0, 0, 0, 1); tick();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 1, k, 1, 'h100 + k, 1); tick();
        end
        chk("midrst third write addr", 32'(wr_addr), 32'h52);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_idle_zero("midrst");
        drive(0, 0, 0, 1, 'hDEAD, 1, 'hBEEF, 1); tick();
        drive(1, 'h40, 2, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 'hA1, 1, 'hA2, 1); tick();
        drive(0, 0, 0, 1, 'hB1, 1, 'hB2, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("post-rst w0 en", 32'(wr_en), 32'd1);
        chk("post-rst w0 addr", 32'(wr_addr), 32'h40);
        chk("post-rst w0 data", wr_data, 32'h00A200A1);
        tick();
        chk("post-rst w1 addr", 32'(wr_addr), 32'h41);
        chk("post-rst w1 data", wr_data, 32'h00B200B1);
        tick();
        chk("post-rst done", 32'(done), 32'd1);
        chk("post-rst wr_en low", 32'(wr_en), 32'd0);
        tick();

        // Random transactions: gappy lanes, random skew, random wr_ready, occasional excess element
        for (int n = 0; n < 60; n++) begin
            rows = $urandom_range(1, 10);
            base = $urandom_range(0, 255);
            tot1 = rows + (($urandom_range(0, 7) == 0) ? 1 : 0);
            tot2 = rows + (($urandom_range(0, 7) == 0) ? 1 : 0);
            skew = $urandom_range(0, 2);
            drive(1, base, rows, 0, 0, 0, 0, 1); tick();
            s1 = 0; s2 = 0;
            for (int c = 0; c < 200 && (s1 < tot1 || s2 < tot2); c++) begin
                v1 = (s1 < tot1 && $urandom_range(0, 3) != 0) ? 1 : 0;
                v2 = (c >= skew && s2 < tot2 && $urandom_range(0, 3) != 0) ? 1 : 0;
                drive(0, 0, 0, v1, $urandom_range(0, 65535), v2, $urandom_range(0, 65535),
                      ($urandom_range(0, 3) != 0) ? 1 : 0);
                s1 += v1; s2 += v2;
                tick();
            end
            for (int c = 0; c < 60 && (m_busy || m_done); c++) begin
                drive(0, 0, 0, 0, 0, 0, 0, ($urandom_range(0, 3) != 0) ? 1 : 0);
                tick();
            end
            if (m_busy || m_done) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
